// File: rtl/blob_feeder.sv
// blob_feeder: transmit end of a blob stream. A host preloads a word buffer
// and pulses start; the block then plays NUM_WORDS words out through a
// rdy/en/eop handshake, tagging eop on the last word of the frame.
// Optional feature macro: BLOB_FEEDER_LOOP_EN adds a 'loop' input that
// restarts the frame automatically after each eop transfer.
module blob_feeder #(
  parameter int DW        = 128,
  parameter int ADDR_W    = 12,
  parameter int NUM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DW-1:0]     host_wr_data,
  input  logic              start,
`ifdef BLOB_FEEDER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  input  logic              blob_dout_rdy,
  output logic              blob_dout_en,
  output logic              blob_dout_eop,
  output logic [DW-1:0]     blob_dout
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NW    = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t state;

  // Word buffer and its registered read port
  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     rd_data;
  logic              rd_valid;  // read issued last cycle, rd_data now valid
  logic              rd_eop;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W-1:0] rd_addr;

  // Two-entry output FIFO
  logic [DW-1:0]     fifo_data [2];
  logic              fifo_eop  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;

`ifdef BLOB_FEEDER_LOOP_EN
  logic              loop_q;
`endif

  logic              fifo_has;
  logic              head_valid;
  logic [DW-1:0]     head_data;
  logic              head_eop;
  logic              xfer;
  logic              fifo_pop;
  logic              fifo_push;
  logic [2:0]        occ_after;
  logic              rd_issue;
  logic              eop_xfer;

  assign rd_addr = issued[ADDR_W-1:0];

  // Head selection and read issue. The in-flight read word is treated as the
  // youngest queue entry: when the FIFO is empty it is presented directly, so
  // the first word can transfer one cycle after its read is issued.
  always_comb begin
    fifo_has   = (fifo_cnt != 2'd0);
    head_valid = fifo_has | rd_valid;
    head_data  = fifo_has ? fifo_data[rd_ptr] : rd_data;
    head_eop   = fifo_has ? fifo_eop[rd_ptr]  : rd_eop;
    xfer       = head_valid & blob_dout_rdy;
    fifo_pop   = xfer & fifo_has;
    fifo_push  = rd_valid & ~(xfer & ~fifo_has);
    occ_after  = {1'b0, fifo_cnt} + {2'b00, rd_valid} - {2'b00, xfer};
    rd_issue   = (state == S_STREAM) && (issued < NW) && (occ_after < 3'd2);
    eop_xfer   = xfer & head_eop;
  end

  assign blob_dout_en  = xfer;
  assign blob_dout_eop = eop_xfer;
  assign blob_dout     = head_valid ? head_data : '0;

  // Buffer: host writes outside STREAM, registered read when a read issues
  always_ff @(posedge clk) begin
    if (host_wr_en && (state != S_STREAM))
      mem[host_wr_addr] <= host_wr_data;
    if (rd_issue)
      rd_data <= mem[rd_addr];
  end

  // FIFO storage (contents need no reset; occupancy is tracked separately)
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_eop[wr_ptr]  <= rd_eop;
    end
  end

  // FIFO pointers, occupancy and read-pipeline valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      rd_valid <= 1'b0;
      rd_eop   <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= ~wr_ptr;
      if (fifo_pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
      rd_valid <= rd_issue;
      if (rd_issue) rd_eop <= (issued == LAST);
    end
  end

  // Frame FSM with registered busy/done and the read counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      issued <= '0;
`ifdef BLOB_FEEDER_LOOP_EN
      loop_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_STREAM;
            busy   <= 1'b1;
            issued <= '0;
          end
        end
        S_STREAM: begin
          if (rd_issue) issued <= issued + 1'b1;
          if (eop_xfer) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            issued <= '0;
`ifdef BLOB_FEEDER_LOOP_EN
            loop_q <= loop;
`endif
          end
        end
        S_DONE: begin
`ifdef BLOB_FEEDER_LOOP_EN
          if (loop_q) begin
            state <= S_STREAM;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
